// File: rtl/serial_link_master_if.sv
// serial_link_master_if
//   Board-facing pins of the 4-slot serial register link.
//   master modport: the host end (serial_link_master) drives clock/data/sync/reset
//                   and receives the board's serial output.
//   slave modport : the board end (or a board model) with directions reversed.
//   Members:
//     link_clk   host -> board  link clock (board clk_data)
//     link_data  host -> board  serial data, LSB first (board datainbit)
//     link_sync  host -> board  frame sync strobe (board data_sync_en)
//     link_rst   host -> board  board reset pulse (board sys_reset)
//     link_din   board -> host  serial data from the board (board dataoutbit)
interface serial_link_master_if;
    logic link_clk;
    logic link_data;
    logic link_sync;
    logic link_rst;
    logic link_din;

    modport master (
        output link_clk,
        output link_data,
        output link_sync,
        output link_rst,
        input  link_din
    );

    modport slave (
        input  link_clk,
        input  link_data,
        input  link_sync,
        input  link_rst,
        output link_din
    );
endinterface

// File: rtl/serial_link_master.sv
// serial_link_master
//   Host end of the 4-slot serial register link. Generates the link clock,
//   shifts one 32-bit word per frame to the board (LSB first) while capturing
//   the board's word, then issues a one-pulse sync. Slots cycle 1,2,3,0 after
//   each link reset, mirroring the board's own slot counter.
//   Optional feature macro: SLINK_CPU_STEP_EN (adds cpu_step output).
// Ports
//   clk_sys, sys_reset      clock, asynchronous active-high reset
//   run                     keep framing while 1; stop at a frame boundary on 0
//   tx_instr, tx_memdata    words sent in slot 1 and slot 3 (latched at frame start)
//   link                    board pins (see serial_link_master_if)
//   rx_pc/rx_memaddr/rx_memdata  last words received for board registers 0/2/3
//   rx_valid, rx_slot       update strobe and the board register index updated
//   round_done              pulse after every slot-0 sync
//   busy                    high whenever the FSM is not IDLE
//   cpu_step                (SLINK_CPU_STEP_EN only) one CLK_DIV-cycle pulse per round
// rx_valid is a single-cycle strobe with no ready/back-pressure: rx_slot and the
// rx_* register it names are valid in the same cycle and stay until the next update.
module serial_link_master #(
    parameter int CLK_DIV    = 4,
    parameter int RST_HALVES = 4
) (
    input  logic                        clk_sys,
    input  logic                        sys_reset,
    input  logic                        run,
    input  logic [31:0]                 tx_instr,
    input  logic [31:0]                 tx_memdata,
    serial_link_master_if.master        link,
    output logic [31:0]                 rx_pc,
    output logic [31:0]                 rx_memaddr,
    output logic [31:0]                 rx_memdata,
    output logic                        rx_valid,
    output logic [1:0]                  rx_slot,
    output logic                        round_done,
    output logic                        busy
`ifdef SLINK_CPU_STEP_EN
    ,
    output logic                        cpu_step
`endif
);
    localparam int PW = $clog2(CLK_DIV);
    // One counter serves as LRST half-period count and as SHIFT bit index.
    localparam int CW = ($clog2(RST_HALVES) > 5) ? $clog2(RST_HALVES) : 5;

    typedef enum logic [1:0] {IDLE, LRST, SHIFT, SYNC} state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase;
    logic [CW-1:0] cnt;
    logic [1:0]    slot, slot_n;
    logic [31:0]   tx_word, tx_next, rx_shift;
    logic          clk_level, data_bit, sync_bit, rst_pulse;
    logic          din_meta, din_sync;
    logic          first_frame;
    logic          half_end, launch, frame_end, start_frame;
    logic [4:0]    bit_next;

    assign link.link_clk  = clk_level;
    assign link.link_data = data_bit;
    assign link.link_sync = sync_bit;
    assign link.link_rst  = rst_pulse;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk_sys or posedge sys_reset) begin
        if (sys_reset) state <= IDLE;
        else           state <= state_n;
    end

    // launch: falling link_clk edge inside SHIFT; frame_end: falling edge closing SYNC.
    always_comb begin
        state_n   = state;
        launch    = 1'b0;
        frame_end = 1'b0;
        half_end  = (phase == PW'(CLK_DIV - 1));
        case (state)
            IDLE:  if (run) state_n = LRST;
            LRST:  if (half_end && cnt == CW'(RST_HALVES - 1)) state_n = SHIFT;
            SHIFT: if (half_end && clk_level) begin
                       launch = 1'b1;
                       if (cnt == CW'(31)) state_n = SYNC;
                   end
            SYNC:  if (half_end && clk_level) begin
                       frame_end = 1'b1;
                       state_n   = run ? SHIFT : IDLE;
                   end
            default: state_n = IDLE;
        endcase
        // A frame starts at the launch edge of its first pulse: after LRST or after a sync.
        start_frame = (state == LRST && state_n == SHIFT) || (frame_end && run);
        slot_n      = slot + 2'd1;
        case (slot_n)
            2'd1:    tx_next = tx_instr;
            2'd3:    tx_next = tx_memdata;
            default: tx_next = '0;
        endcase
        bit_next = cnt[4:0] + 5'd1;
    end

    always_ff @(posedge clk_sys or posedge sys_reset) begin
        if (sys_reset) begin
            phase       <= '0;
            cnt         <= '0;
            slot        <= '0;
            tx_word     <= '0;
            rx_shift    <= '0;
            clk_level   <= 1'b0;
            data_bit    <= 1'b0;
            sync_bit    <= 1'b0;
            rst_pulse   <= 1'b0;
            din_meta    <= 1'b0;
            din_sync    <= 1'b0;
            first_frame <= 1'b0;
            rx_pc       <= '0;
            rx_memaddr  <= '0;
            rx_memdata  <= '0;
            rx_valid    <= 1'b0;
            rx_slot     <= '0;
            round_done  <= 1'b0;
        end else begin
            din_meta   <= link.link_din;
            din_sync   <= din_meta;
            rx_valid   <= 1'b0;
            round_done <= 1'b0;

            if (state == IDLE || half_end) phase <= '0;
            else                           phase <= phase + 1'b1;

            if ((state == SHIFT || state == SYNC) && half_end)
                clk_level <= ~clk_level;

            if (state == IDLE && run) begin
                rst_pulse   <= 1'b1;
                cnt         <= '0;
                slot        <= '0;
                first_frame <= 1'b1;
            end
            if (state == LRST && half_end) cnt <= cnt + 1'b1;
            if (state == LRST && state_n == SHIFT) rst_pulse <= 1'b0;

            // The board moved dataoutbit at the preceding rising edge; it has
            // cleared the synchroniser by now because CLK_DIV >= 3.
            if (launch) begin
                rx_shift[cnt[4:0]] <= din_sync;
                cnt                <= cnt + 1'b1;
                if (state_n == SYNC) begin
                    sync_bit <= 1'b1;
                    data_bit <= 1'b0;
                end else begin
                    data_bit <= tx_word[bit_next];
                end
            end

            // Frame in slot s carries board register (s-1) mod 4.
            if (frame_end) begin
                sync_bit    <= 1'b0;
                data_bit    <= 1'b0;
                first_frame <= 1'b0;
                round_done  <= (slot == 2'd0);
                if (!first_frame) begin
                    case (slot)
                        2'd1: begin rx_pc      <= rx_shift; rx_valid <= 1'b1; rx_slot <= 2'd0; end
                        2'd3: begin rx_memaddr <= rx_shift; rx_valid <= 1'b1; rx_slot <= 2'd2; end
                        2'd0: begin rx_memdata <= rx_shift; rx_valid <= 1'b1; rx_slot <= 2'd3; end
                        default: ;
                    endcase
                end
            end

            if (start_frame) begin
                slot     <= slot_n;
                tx_word  <= tx_next;
                data_bit <= tx_next[0];
                cnt      <= '0;
            end
        end
    end

`ifdef SLINK_CPU_STEP_EN
    logic [PW-1:0] step_cnt;

    always_ff @(posedge clk_sys or posedge sys_reset) begin
        if (sys_reset) begin
            cpu_step <= 1'b0;
            step_cnt <= '0;
        end else if (round_done) begin
            cpu_step <= 1'b1;
            step_cnt <= '0;
        end else if (cpu_step) begin
            if (step_cnt == PW'(CLK_DIV - 1)) cpu_step <= 1'b0;
            else                              step_cnt <= step_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_serial_link_master.sv
// tb_serial_link_master
//   Drives serial_link_master against a behavioural board model and checks
//   link timing, board-side latching and the rx_* scoreboard.
module tb_serial_link_master;
    localparam int CLK_DIV    = 4;
    localparam int RST_HALVES = 4;
    localparam int FRAME_CYC  = 33 * 2 * CLK_DIV;
    localparam int ROUND_CYC  = 4 * FRAME_CYC;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_sys = 1'b0;
    logic        sys_reset;
    logic        run;
    logic [31:0] tx_instr, tx_memdata;
    logic [31:0] rx_pc, rx_memaddr, rx_memdata;
    logic        rx_valid;
    logic [1:0]  rx_slot;
    logic        round_done, busy;
`ifdef SLINK_CPU_STEP_EN
    logic        cpu_step;
`endif

    serial_link_master_if link();

    serial_link_master #(.CLK_DIV(CLK_DIV), .RST_HALVES(RST_HALVES)) dut (
        .clk_sys    (clk_sys),
        .sys_reset  (sys_reset),
        .run        (run),
        .tx_instr   (tx_instr),
        .tx_memdata (tx_memdata),
        .link       (link),
        .rx_pc      (rx_pc),
        .rx_memaddr (rx_memaddr),
        .rx_memdata (rx_memdata),
        .rx_valid   (rx_valid),
        .rx_slot    (rx_slot),
        .round_done (round_done),
        .busy       (busy)
`ifdef SLINK_CPU_STEP_EN
        ,
        .cpu_step   (cpu_step)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- counters / check ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- board model ----------------
    logic [1:0]  b_slot;
    logic        b_new;
    int          b_bit;
    logic [31:0] b_in, b_sh;
    logic [31:0] b_reg_in [4];
    logic [31:0] board_out [4];

    always @(posedge link.link_clk or posedge link.link_rst) begin
        if (link.link_rst) begin
            b_slot = 2'd0;
            b_new  = 1'b1;
            b_bit  = 0;
        end else if (link.link_sync) begin
            b_reg_in[b_slot] = b_in;
            b_sh             = board_out[b_slot];
            b_new            = 1'b1;
        end else begin
            if (b_new) begin
                b_slot = b_slot + 2'd1;
                b_bit  = 0;
                b_new  = 1'b0;
            end
            link.link_din = b_sh[b_bit];
            b_in[b_bit]   = link.link_data;
            b_bit         = b_bit + 1;
        end
    end

    // ---------------- monitor + reference model + scoreboard ----------------
    int          cyc = 0;
    always @(posedge clk_sys) cyc = cyc + 1;

    logic        prev_clk = 1'b0, prev_rst = 1'b0;
    int          rst_rises = 0, rst_rise_cyc = 0, rst_fall_cyc = 0;
    int          frame_no = 0, bit_in_frame = 0, total_rise = 0;
    logic        in_frame = 1'b0, last_rise_sync = 1'b0;
    int          frame_cyc[$];
    logic [31:0] exp_tx = '0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_item;
    logic        round_pending = 1'b0;
    int          n_round = 0, n_round_exp = 0, last_round_cyc = 0;
    int          ridx;
    logic [31:0] mon_word;
`ifdef SLINK_CPU_STEP_EN
    logic        prev_step = 1'b0;
    int          step_start = 0, n_step = 0;
`endif

    always @(negedge clk_sys) begin
        if (link.link_rst && !prev_rst) begin
            rst_rises++;
            rst_rise_cyc = cyc;
            frame_no     = 0;
            in_frame     = 1'b0;
            bit_in_frame = 0;
            frame_cyc.delete();
        end
        if (!link.link_rst && prev_rst) rst_fall_cyc = cyc;

        if (link.link_clk && !prev_clk) begin
            total_rise++;
            last_rise_sync = link.link_sync;
            if (!link.link_sync) begin
                if (!in_frame) begin
                    frame_no++;
                    in_frame     = 1'b1;
                    bit_in_frame = 0;
                    frame_cyc.push_back(cyc);
                    case (frame_no % 4)
                        1:       exp_tx = tx_instr;
                        3:       exp_tx = tx_memdata;
                        default: exp_tx = '0;
                    endcase
                end
                bit_in_frame++;
            end else begin
                check("bits_per_frame", bit_in_frame, 32);
                check("board_latch", b_reg_in[frame_no % 4], exp_tx);
                in_frame = 1'b0;
                if (frame_no % 4 == 0) begin
                    round_pending = 1'b1;
                    n_round_exp++;
                end
                // Slot s frame returns board register (s-1) mod 4; register 1 and
                // the first frame after a link reset produce nothing.
                if (frame_no != 1 && frame_no % 4 != 2) begin
                    ridx = (frame_no + 3) % 4;
                    exp_q.push_back({2'(ridx), board_out[ridx]});
                end
            end
        end

        if (rx_valid) begin
            case (rx_slot)
                2'd0:    mon_word = rx_pc;
                2'd2:    mon_word = rx_memaddr;
                2'd3:    mon_word = rx_memdata;
                default: mon_word = 32'hxxxx_xxxx;
            endcase
            check("rx_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                check("rx_word", {rx_slot, mon_word}, exp_item);
            end
        end

        if (round_done) begin
            check("round_done_slot0", round_pending, 1'b1);
            round_pending  = 1'b0;
            n_round++;
            last_round_cyc = cyc;
        end

`ifdef SLINK_CPU_STEP_EN
        if (cpu_step && !prev_step) begin
            check("step_start", cyc - last_round_cyc, 1);
            step_start = cyc;
            n_step++;
        end
        if (!cpu_step && prev_step) check("step_len", cyc - step_start, CLK_DIV);
        prev_step = cpu_step;
`endif
        prev_clk = link.link_clk;
        prev_rst = link.link_rst;
    end

    // ---------------- directed sequence ----------------
    int rr, nr, tr;

    initial begin
        sys_reset     = 1'b1;
        run           = 1'b0;
        tx_instr      = 32'hA5A5_0013;
        tx_memdata    = $urandom;
        board_out[0]  = 32'h0000_0040;
        board_out[1]  = $urandom;
        board_out[2]  = 32'h0000_1000;
        board_out[3]  = 32'hDEAD_BEEF;
        b_sh          = '0;
        link.link_din = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Reset state
        check("rst_rx_pc", rx_pc, 0);
        check("rst_rx_memaddr", rx_memaddr, 0);
        check("rst_rx_memdata", rx_memdata, 0);
        check("rst_flags", {rx_valid, rx_slot, round_done, busy}, 0);
        check("rst_link", {link.link_clk, link.link_data, link.link_sync, link.link_rst}, 0);
`ifdef SLINK_CPU_STEP_EN
        check("rst_cpu_step", cpu_step, 0);
`endif
        sys_reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("idle_without_run", busy, 0);

        // Framing from reset: timing, slot-1 word, two full rounds
        run = 1'b1;
        for (int i = 0; i < 3 * ROUND_CYC && n_round < 2; i++) @(negedge clk_sys);
        @(negedge clk_sys);
        check("wait_round2", n_round, 2);
        check("lrst_len", rst_fall_cyc - rst_rise_cyc, RST_HALVES * CLK_DIV);
        check("frames_seen", frame_cyc.size() >= 2, 1'b1);
        check("first_rise_delay", frame_cyc[0] - rst_fall_cyc, CLK_DIV);
        check("frame_len", frame_cyc[1] - frame_cyc[0], FRAME_CYC);
        check("board_in1", b_reg_in[1], 32'hA5A5_0013);
        check("rx_pc_round2", rx_pc, 32'h0000_0040);
        check("rx_memaddr_round2", rx_memaddr, 32'h0000_1000);
        check("rx_memdata_round2", rx_memdata, 32'hDEAD_BEEF);

        // tx change in the middle of a slot-1 frame must not reach the board this frame
        for (int i = 0; i < 2 * ROUND_CYC && !(in_frame && bit_in_frame == 5 && frame_no % 4 == 1); i++)
            @(negedge clk_sys);
        check("wait_slot1_bit5", in_frame && bit_in_frame == 5 && frame_no % 4 == 1, 1'b1);
        tx_instr   = $urandom;
        tx_memdata = $urandom;

        // Drop run at bit 10: frame completes with its sync, then IDLE
        for (int i = 0; i < 2 * FRAME_CYC && !(in_frame && bit_in_frame == 10); i++) @(negedge clk_sys);
        check("wait_bit10", in_frame && bit_in_frame == 10, 1'b1);
        run = 1'b0;
        for (int i = 0; i < FRAME_CYC + 20 && busy; i++) @(negedge clk_sys);
        check("stop_busy", busy, 0);
        check("stop_link_clk", link.link_clk, 0);
        check("stop_frame_done", {in_frame, last_rise_sync}, 2'b01);
        tr = total_rise;
        repeat (40) @(negedge clk_sys);
        check("idle_no_clock", total_rise, tr);
        check("stop_queue_empty", exp_q.size(), 0);

        // Restart: LRST reissued, slots realign from 1
        for (int k = 0; k < 4; k++) board_out[k] = $urandom;
        rr  = rst_rises;
        nr  = n_round;
        run = 1'b1;
        for (int i = 0; i < 10 && rst_rises == rr; i++) @(negedge clk_sys);
        check("lrst_reissued", rst_rises, rr + 1);
        for (int i = 0; i < 2 * ROUND_CYC && n_round < nr + 1; i++) @(negedge clk_sys);
        @(negedge clk_sys);
        check("wait_restart_round", n_round, nr + 1);
        check("rx_memaddr_restart", rx_memaddr, board_out[2]);
        check("rx_memdata_restart", rx_memdata, board_out[3]);

        // sys_reset at bit 20: outputs clear at once, fresh LRST follows
        for (int i = 0; i < 2 * FRAME_CYC && !(in_frame && bit_in_frame == 20); i++) @(negedge clk_sys);
        check("wait_bit20", in_frame && bit_in_frame == 20, 1'b1);
        sys_reset = 1'b1;
        #1;
        check("midrst_rx", {rx_pc, rx_memaddr}, 0);
        check("midrst_rx_memdata", rx_memdata, 0);
        check("midrst_flags", {rx_valid, rx_slot, round_done, busy}, 0);
        check("midrst_link", {link.link_clk, link.link_data, link.link_sync, link.link_rst}, 0);
        @(negedge clk_sys);
        for (int k = 0; k < 4; k++) board_out[k] = $urandom;
        tx_instr   = $urandom;
        tx_memdata = $urandom;
        rr         = rst_rises;
        nr         = n_round;
        sys_reset  = 1'b0;
        for (int i = 0; i < 10 && rst_rises == rr; i++) @(negedge clk_sys);
        check("lrst_after_reset", rst_rises, rr + 1);
        for (int i = 0; i < 3 * ROUND_CYC && n_round < nr + 2; i++) @(negedge clk_sys);
        @(negedge clk_sys);
        check("wait_reset_rounds", n_round, nr + 2);
        check("rx_pc_after_reset", rx_pc, board_out[0]);
        check("rx_memaddr_after_reset", rx_memaddr, board_out[2]);
        check("rx_memdata_after_reset", rx_memdata, board_out[3]);

        // Wind down and final bookkeeping
        run = 1'b0;
        for (int i = 0; i < FRAME_CYC + 20 && busy; i++) @(negedge clk_sys);
        repeat (2 * CLK_DIV + 2) @(negedge clk_sys);
        check("final_idle", busy, 0);
        check("final_queue_empty", exp_q.size(), 0);
        check("round_count", n_round, n_round_exp);
        check("round_pending_clear", round_pending, 0);
`ifdef SLINK_CPU_STEP_EN
        check("step_count", n_step, n_round);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
